// File: rtl/dma_chan_sched.sv
// Round-robin descriptor scheduler feeding a single DMA engine, with chain lock,
// per-channel done-IRQ counters and a sticky error state.
module dma_chan_sched #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        req_valid_i,
    output logic [NUM_CH-1:0]        req_ready_o,
    input  logic [NUM_CH-1:0][95:0]  req_desc_i,
    input  logic [NUM_CH-1:0]        req_last_i,
    output logic                     eng_go_o,
    output logic [95:0]              eng_desc_o,
    input  logic                     eng_active_i,
    input  logic                     eng_done_i,
    input  logic                     eng_error_i,
    input  logic [NUM_CH-1:0]        irq_clr_i,
    input  logic                     err_clr_i,
    output logic [NUM_CH-1:0]        done_irq_o,
    output logic                     error_irq_o,
    output logic [2:0]               err_ch_o,
    output logic                     busy_o
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StRun, StErr} state_e;

    state_e                         state_q;
    logic                           go_q;
    logic [95:0]                    desc_q;
    logic                           last_q;
    logic [CH_W-1:0]                ch_q;
    logic [CH_W-1:0]                ptr_q;
    logic                           lock_q;
    logic [CH_W-1:0]                lock_ch_q;
    logic                           err_irq_q;
    logic [2:0]                     err_ch_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_d;

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] grant_vec;
    logic [NUM_CH-1:0] inc_vec;
    logic              grant_any;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   idx;
    logic              zero_len;
    logic              fin;
    logic              done_ok;
    logic              done_err;

    // Search starts one past the last granted channel; rstn gates ready during reset.
    always_comb begin
        elig      = lock_q ? (NUM_CH'(1) << lock_ch_q) : '1;
        cand      = req_valid_i & elig;
        grant_any = 1'b0;
        grant_ch  = '0;
        idx       = '0;
        grant_vec = '0;
        if (rstn && state_q == StIdle) begin
            for (int i = 1; i <= int'(NUM_CH); i++) begin
                idx = CH_W'((int'(ptr_q) + i) % int'(NUM_CH));
                if (!grant_any && cand[idx]) begin
                    grant_any = 1'b1;
                    grant_ch  = idx;
                end
            end
        end
        if (grant_any) begin
            grant_vec[grant_ch] = 1'b1;
        end
    end

    assign zero_len = (desc_q[31:0] == 32'd0);
    assign fin      = (state_q == StWaitStart || state_q == StRun) && eng_done_i;
    assign done_ok  = (fin && !eng_error_i) || (state_q == StIssue && zero_len);
    assign done_err = fin && eng_error_i;
    assign inc_vec  = (done_ok && last_q) ? (NUM_CH'(1) << ch_q) : '0;

    // Simultaneous increment and clear cancel out.
    always_comb begin
        cnt_d = cnt_q;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (inc_vec[c] && !irq_clr_i[c]) begin
                if (cnt_q[c] != CntMax) cnt_d[c] = cnt_q[c] + 1'b1;
            end else if (!inc_vec[c] && irq_clr_i[c] && cnt_q[c] != '0) begin
                cnt_d[c] = cnt_q[c] - 1'b1;
            end
        end
    end

    always_comb begin
        done_irq_o = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            done_irq_o[c] = |cnt_q[c];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            go_q      <= 1'b0;
            desc_q    <= '0;
            last_q    <= 1'b0;
            ch_q      <= '0;
            ptr_q     <= CH_W'(NUM_CH - 1);
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            err_irq_q <= 1'b0;
            err_ch_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        desc_q  <= req_desc_i[grant_ch];
                        last_q  <= req_last_i[grant_ch];
                        ch_q    <= grant_ch;
                        ptr_q   <= grant_ch;
                        go_q    <= |req_desc_i[grant_ch][31:0];
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    go_q    <= 1'b0;
                    state_q <= zero_len ? StIdle : StWaitStart;
                end
                StWaitStart: begin
                    if (eng_active_i) state_q <= StRun;
                end
                StRun: begin
                    state_q <= StRun;
                end
                StErr: begin
                    if (err_clr_i) begin
                        err_irq_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Completion overrides the per-state next state above.
            if (done_ok) begin
                state_q   <= StIdle;
                lock_q    <= !last_q;
                lock_ch_q <= ch_q;
            end
            if (done_err) begin
                state_q   <= StErr;
                err_irq_q <= 1'b1;
                err_ch_q  <= 3'(ch_q);
                lock_q    <= 1'b0;
            end
        end
    end

    assign req_ready_o = grant_vec;
    assign eng_go_o    = go_q;
    assign eng_desc_o  = desc_q;
    assign error_irq_o = err_irq_q;
    assign err_ch_o    = err_ch_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched: arbitration, chain lock, zero-length, error,
// counter saturation and mid-transfer reset.
module tb_dma_chan_sched;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic [NUM_CH-1:0]       req_valid;
    logic [NUM_CH-1:0]       req_ready;
    logic [NUM_CH-1:0][95:0] req_desc;
    logic [NUM_CH-1:0]       req_last;
    logic                    eng_go;
    logic [95:0]             eng_desc;
    logic                    eng_active;
    logic                    eng_done;
    logic                    eng_error;
    logic [NUM_CH-1:0]       irq_clr;
    logic                    err_clr;
    logic [NUM_CH-1:0]       done_irq;
    logic                    error_irq;
    logic [2:0]              err_ch;
    logic                    busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] d0, d0z, d1a, d1b, d1c, d2, d2e, d2z, d3;

    always #5 clk = ~clk;

    dma_chan_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_desc_i   (req_desc),
        .req_last_i   (req_last),
        .eng_go_o     (eng_go),
        .eng_desc_o   (eng_desc),
        .eng_active_i (eng_active),
        .eng_done_i   (eng_done),
        .eng_error_i  (eng_error),
        .irq_clr_i    (irq_clr),
        .err_clr_i    (err_clr),
        .done_irq_o   (done_irq),
        .error_irq_o  (error_irq),
        .err_ch_o     (err_ch),
        .busy_o       (busy)
    );

    function automatic logic [95:0] mk(input logic [31:0] s, input logic [31:0] d,
                                       input logic [31:0] n);
        return {s, d, n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the ISSUE cycle; returns in the cycle after the done pulse.
    task automatic run_engine(input int n, input logic err, input logic [95:0] exp_desc);
        step();
        chk("go_single_cycle", eng_go, 1'b0);
        eng_active = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            chk("desc_stable", eng_desc, exp_desc);
        end
        eng_done  = 1'b1;
        eng_error = err;
        step();
        eng_done   = 1'b0;
        eng_error  = 1'b0;
        eng_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d0  = mk(32'h0000_0100, 32'h0000_0200, 32'd16);
        d0z = mk(32'h0000_0900, 32'h0000_0a00, 32'd0);
        d1a = mk(32'h0000_0500, 32'h0000_0600, 32'd32);
        d1b = mk(32'h0000_0510, 32'h0000_0610, 32'd64);
        d1c = mk(32'h0000_0520, 32'h0000_0620, 32'd8);
        d2  = mk(32'h0000_0300, 32'h0000_0400, 32'd8);
        d2e = mk(32'h0000_0b00, 32'h0000_0c00, 32'd12);
        d2z = mk(32'h0000_0d00, 32'h0000_0e00, 32'd0);
        d3  = mk(32'h0000_0700, 32'h0000_0800, 32'd4);

        rstn = 1'b0; req_valid = '0; req_desc = '0; req_last = '0;
        eng_active = 1'b0; eng_done = 1'b0; eng_error = 1'b0; irq_clr = '0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_go", eng_go, 1'b0);
        chk("rst_desc", eng_desc, 96'd0);
        chk("rst_done_irq", done_irq, 4'b0000);
        chk("rst_error_irq", error_irq, 1'b0);
        chk("rst_err_ch", err_ch, 3'd0);
        chk("rst_busy", busy, 1'b0);
        req_valid = '0;
        rstn = 1'b1;
        step();

        // Channels 0 and 2 together: ch0 first, then ch2.
        req_desc[0] = d0; req_desc[2] = d2; req_last = 4'b1111; req_valid = 4'b0101;
        #1 chk("rr_grant_ch0", req_ready, 4'b0001);
        step(); req_valid[0] = 1'b0; #1;
        chk("go_after_grant", eng_go, 1'b1);
        chk("eng_desc_ch0", eng_desc, d0);
        chk("no_ready_in_issue", req_ready, 4'b0000);
        run_engine(5, 1'b0, d0);
        #1 chk("irq_after_ch0", done_irq, 4'b0001);
        chk("rr_grant_ch2", req_ready, 4'b0100);
        step(); req_valid[2] = 1'b0; #1;
        chk("go_ch2", eng_go, 1'b1);
        chk("eng_desc_ch2", eng_desc, d2);
        run_engine(5, 1'b0, d2);
        #1 chk("irq_0101", done_irq, 4'b0101);
        chk("idle_not_busy", busy, 1'b0);
        irq_clr = 4'b0101; step(); irq_clr = '0;
        chk("irq_cleared", done_irq, 4'b0000);

        // Chain on ch1 locks out ch3 until its last descriptor.
        req_desc[1] = d1a; req_last[1] = 1'b0; req_valid = 4'b0010;
        #1 chk("grant_ch1_a", req_ready, 4'b0010);
        step(); req_desc[3] = d3; req_valid = 4'b1000; #1;
        chk("go_ch1_a", eng_go, 1'b1);
        run_engine(3, 1'b0, d1a);
        #1 chk("lock_blocks_ch3", req_ready, 4'b0000);
        step();
        chk("lock_blocks_ch3_hold", req_ready, 4'b0000);
        chk("lock_idle_not_busy", busy, 1'b0);
        req_desc[1] = d1b; req_valid = 4'b1010;
        #1 chk("grant_ch1_b", req_ready, 4'b0010);
        step(); req_valid[1] = 1'b0;
        run_engine(3, 1'b0, d1b);
        #1 chk("lock_blocks_ch3_b", req_ready, 4'b0000);
        chk("no_irq_midchain", done_irq, 4'b0000);
        req_desc[1] = d1c; req_last[1] = 1'b1; req_valid[1] = 1'b1;
        #1 chk("grant_ch1_c", req_ready, 4'b0010);
        step(); req_valid[1] = 1'b0;
        run_engine(3, 1'b0, d1c);
        #1 chk("unlock_grant_ch3", req_ready, 4'b1000);
        chk("irq_ch1", done_irq, 4'b0010);
        step(); req_valid[3] = 1'b0;
        run_engine(2, 1'b0, d3);
        #1 chk("irq_1010", done_irq, 4'b1010);
        irq_clr = 4'b1010; step(); irq_clr = '0;
        chk("ch1_count_one", done_irq, 4'b0000);

        // Zero-length on ch0: no go, counter two cycles after grant.
        req_desc[0] = d0z; req_valid = 4'b0001;
        #1 chk("grant_zero", req_ready, 4'b0001);
        step(); req_valid = '0; #1;
        chk("zero_no_go", eng_go, 1'b0);
        chk("zero_busy", busy, 1'b1);
        step();
        chk("zero_irq", done_irq, 4'b0001);
        chk("zero_no_go_late", eng_go, 1'b0);
        chk("zero_back_idle", busy, 1'b0);
        irq_clr = 4'b0001; step(); irq_clr = '0;

        // Engine error on ch2.
        req_desc[2] = d2e; req_valid = 4'b0100;
        #1 chk("grant_ch2_err", req_ready, 4'b0100);
        step(); req_valid = '0;
        run_engine(2, 1'b1, d2e);
        #1 chk("error_irq_set", error_irq, 1'b1);
        chk("err_ch_2", err_ch, 3'd2);
        chk("err_busy", busy, 1'b1);
        req_desc[0] = d0; req_valid = 4'b0001;
        #1 chk("err_no_grant", req_ready, 4'b0000);
        step(); step();
        chk("err_no_grant_hold", req_ready, 4'b0000);
        chk("err_sticky", error_irq, 1'b1);
        chk("err_ch2_cnt_unchanged", done_irq, 4'b0000);
        err_clr = 1'b1; step(); err_clr = 1'b0; #1;
        chk("err_cleared", error_irq, 1'b0);
        chk("err_idle", busy, 1'b0);
        chk("grant_after_clr", req_ready, 4'b0001);
        step(); req_valid = '0; #1;
        chk("go_after_clr", eng_go, 1'b1);
        run_engine(2, 1'b0, d0);
        #1 chk("irq_after_err", done_irq, 4'b0001);
        irq_clr = 4'b0001; step(); irq_clr = '0;

        // Saturation at 3 with CNT_W=2, then inc+clr leaves it unchanged.
        req_desc[0] = d0z;
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0001;
            #1 chk("sat_grant", req_ready, 4'b0001);
            step(); req_valid = '0;
            step();
        end
        req_valid = 4'b0001;
        step(); req_valid = '0; irq_clr = 4'b0001;
        step(); irq_clr = '0;
        for (int k = 0; k < 3; k++) begin
            irq_clr = 4'b0001; step(); irq_clr = '0;
            chk("sat_drain", done_irq[0], (k < 2) ? 1'b1 : 1'b0);
        end
        irq_clr = 4'b0001; step(); irq_clr = '0;
        req_valid = 4'b0001; step(); req_valid = '0; step();
        chk("after_zero_clr_inc", done_irq, 4'b0001);
        irq_clr = 4'b0001; step(); irq_clr = '0;
        chk("clr_at_zero_ignored", done_irq, 4'b0000);

        // Reset during RUN.
        req_desc[2] = d2z; req_valid = 4'b0100;
        step(); req_valid = '0; step();
        chk("pre_reset_irq", done_irq, 4'b0100);
        req_desc[0] = d0; req_valid = 4'b0001;
        #1 chk("grant_pre_reset", req_ready, 4'b0001);
        step(); req_valid = '0;
        chk("go_pre_reset", eng_go, 1'b1);
        step(); eng_active = 1'b1;
        step();
        chk("run_busy", busy, 1'b1);
        eng_done = 1'b1; rstn = 1'b0; #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_go", eng_go, 1'b0);
        chk("mid_rst_desc", eng_desc, 96'd0);
        chk("mid_rst_ready", req_ready, 4'b0000);
        chk("mid_rst_irq", done_irq, 4'b0000);
        chk("mid_rst_err", error_irq, 1'b0);
        step(); eng_done = 1'b0; eng_active = 1'b0;
        chk("rst_no_cnt_update", done_irq, 4'b0000);
        rstn = 1'b1; step();
        req_desc[1] = d1a; req_last = 4'b1111; req_valid = 4'b0011;
        #1 chk("ptr_reset_grant_ch0", req_ready, 4'b0001);
        step(); req_valid = '0; #1;
        chk("go_after_rst", eng_go, 1'b1);
        chk("desc_after_rst", eng_desc, d0);
        run_engine(2, 1'b0, d0);
        #1 chk("irq_after_rst", done_irq, 4'b0001);
        chk("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
